frame_buf_arbiter: RTL and testbench
====================================

// Module: frame_buf_arbiter
// PURPOSE
//  Shares the frame buffer between VGA display, camera capture and an image-processing engine.
//  Read port B: VGA reads have absolute priority; processing reads use free cycles (req/gnt handshake).
//  Write port A: capture writes are gated so processing can freeze one whole frame.
//  Lock/unlock takes effect only at frame boundaries.
//  Sits between ov7670_capture, vga_display and frame_buffer in the camera top.
// PARAMETERS
//  c_nb_img_pxls  13  address width (80x60=4800 pixels)
//  c_nb_buf       12  pixel word width (RGB444)
//  c_rd_lat        1  frame_buffer read latency in clk cycles (1..3)
// PORTS
//  clk            in   1              system clock (100 MHz)
//  rst            in   1              synchronous, active-high reset
//  vga_rd         in   1              VGA read strobe (one cycle, on new_pxl)
//  vga_addr       in   c_nb_img_pxls  VGA read address
//  vga_pixel      out  c_nb_buf       VGA pixel, held until next VGA read returns
//  proc_req       in   1              processing read request (level)
//  proc_addr      in   c_nb_img_pxls  processing address, stable while proc_req=1 and gnt=0
//  proc_gnt       out  1              one-cycle pulse: proc_addr issued to memory
//  proc_dvalid    out  1              one-cycle pulse: proc_data valid
//  proc_data      out  c_nb_buf       processing read data
//  proc_lock_req  in   1              level: request frozen frame
//  proc_lock_ack  out  1              high while capture writes are blocked
//  cap_frame_st   in   1              one-cycle pulse at capture frame start (vsync edge)
//  cap_we         in   1              capture write enable
//  fb_we          out  1              gated write enable to frame_buffer port A
//  fb_addrb       out  c_nb_img_pxls  frame_buffer port B address (registered)
//  fb_doutb       in   c_nb_buf       frame_buffer port B data
// BEHAVIOUR
//  Reset: vga_pixel=0, proc_data=0, proc_gnt=0, proc_dvalid=0, proc_lock_ack=0, fb_addrb=0, state FREE.
//  Read arbitration (per cycle):
//  - vga_rd=1 -> fb_addrb<=vga_addr, tag VGA. proc_gnt=0 even if proc_req=1.
//  - Else proc_req=1 -> fb_addrb<=proc_addr, proc_gnt=1, tag PROC.
//  - Else idle: fb_addrb keeps its value; no tag.
//  - Tag pipeline is c_rd_lat+1 deep (1 cycle registered address + c_rd_lat memory latency).
//    VGA tag out: vga_pixel<=fb_doutb. PROC tag out: proc_data<=fb_doutb, proc_dvalid=1.
//  - Read latency is fixed at c_rd_lat+1 cycles after the request cycle for both requesters.
//  - proc_req held high after a gnt -> back-to-back grants; new address expected the cycle after gnt.
//  - proc_dvalid order equals proc_gnt order. Read data is never dropped or duplicated.
//  Lock FSM (FREE, LOCK_WAIT, LOCKED, FREE_WAIT):
//  - FREE:      proc_lock_req=1 -> LOCK_WAIT.
//  - LOCK_WAIT: cap_frame_st -> LOCKED (ack=1 from next cycle); proc_lock_req=0 -> FREE.
//  - LOCKED:    proc_lock_req=0 -> FREE_WAIT (ack stays 1).
//  - FREE_WAIT: cap_frame_st -> FREE (ack=0 next cycle); proc_lock_req=1 -> LOCKED.
//  - Both events in one cycle: the proc_lock_req transition wins; cap_frame_st is ignored.
//  - fb_we = cap_we & ~blocked. blocked=1 in LOCKED and FREE_WAIT, and in the cycle cap_frame_st
//    fires in LOCK_WAIT. So no write of the new frame slips through.
//  - fb_we combinational (capture addr/data go straight to frame_buffer).
//  - Writes are only ever blocked/unblocked at cap_frame_st: the buffer always holds whole frames.
//  Reset mid-operation: in-flight reads discarded (no dvalid); lock released; state FREE.
// STRUCTURE
//  Shared package: c_nb_img_pxls, c_nb_buf, lock state encoding (2-bit localparams).
//  One sub-module: fb_lock_fsm (lock FSM + fb_we gating). Read arbiter + tag pipeline stay in top.
// TESTING
//  1 VGA only: vga_rd every 4th cycle, addr 0..4799, mem=addr[11:0]
//    -> vga_pixel==addr after c_rd_lat+1 cycles; held between reads.
//  2 Collision: proc_req=1 addr 100 and vga_rd=1 addr 5 in same cycle
//    -> gnt delayed 1 cycle; vga_pixel=5 then proc_data=100 with dvalid.
//  3 Streaming: proc_req held 20 cycles with vga_rd every 4th
//    -> exactly 15 gnt, 15 dvalid, data in order, none lost.
//  4 Lock: lock_req mid-frame -> fb_we follows cap_we until cap_frame_st; then ack=1, fb_we=0 all frame.
//  5 Unlock: drop lock_req -> fb_we stays 0 until next cap_frame_st; then ack=0, writes resume.
//    Lock_req re-raised before that -> stays LOCKED.
//  6 rst=1 with 2 reads in flight and LOCKED -> no dvalid, ack=0, outputs 0 next cycle.

Source files
------------

// File: rtl/frame_buf_arbiter_pkg.sv
// Shared widths and lock-state encoding for the frame buffer arbiter.
package frame_buf_arbiter_pkg;

  localparam int C_NB_IMG_PXLS = 13;  // 80x60 = 4800 pixels
  localparam int C_NB_BUF      = 12;  // RGB444
  localparam int C_RD_LAT      = 1;

  localparam logic [1:0] LK_FREE      = 2'd0;
  localparam logic [1:0] LK_LOCK_WAIT = 2'd1;
  localparam logic [1:0] LK_LOCKED    = 2'd2;
  localparam logic [1:0] LK_FREE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_FREE      = LK_FREE,
    ST_LOCK_WAIT = LK_LOCK_WAIT,
    ST_LOCKED    = LK_LOCKED,
    ST_FREE_WAIT = LK_FREE_WAIT
  } lock_state_t;

endpackage

// File: rtl/frame_buf_arbiter_lock_fsm.sv
// Frame-aligned freeze of capture writes: lock/unlock only switch at capture frame start.
module fb_lock_fsm
  import frame_buf_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic proc_lock_req,
  input  logic cap_frame_st,
  input  logic cap_we,
  output logic fb_we,
  output logic proc_lock_ack
);

  lock_state_t state, state_nx;
  logic        blocked;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_FREE;
    else     state <= state_nx;
  end

  // A lock_req change always wins over a coincident frame start.
  always_comb begin
    state_nx = state;
    blocked  = 1'b0;
    case (state)
      ST_FREE: begin
        if (proc_lock_req) state_nx = ST_LOCK_WAIT;
      end
      ST_LOCK_WAIT: begin
        if (!proc_lock_req) state_nx = ST_FREE;
        else if (cap_frame_st) begin
          state_nx = ST_LOCKED;
          blocked  = 1'b1;  // first write of the new frame must not land
        end
      end
      ST_LOCKED: begin
        blocked = 1'b1;
        if (!proc_lock_req) state_nx = ST_FREE_WAIT;
      end
      ST_FREE_WAIT: begin
        blocked = 1'b1;
        if (proc_lock_req)     state_nx = ST_LOCKED;
        else if (cap_frame_st) state_nx = ST_FREE;
      end
      default: state_nx = ST_FREE;
    endcase
  end

  assign fb_we         = cap_we & ~blocked;
  assign proc_lock_ack = (state == ST_LOCKED) || (state == ST_FREE_WAIT);

endmodule

// File: rtl/frame_buf_arbiter.sv
// Frame buffer sharing: VGA-first read arbitration on port B, frame-gated capture writes on port A.
module frame_buf_arbiter
  import frame_buf_arbiter_pkg::*;
#(
  parameter int c_nb_img_pxls = C_NB_IMG_PXLS,
  parameter int c_nb_buf      = C_NB_BUF,
  parameter int c_rd_lat      = C_RD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vga_rd,
  input  logic [c_nb_img_pxls-1:0] vga_addr,
  output logic [c_nb_buf-1:0]      vga_pixel,
  input  logic                     proc_req,
  input  logic [c_nb_img_pxls-1:0] proc_addr,
  output logic                     proc_gnt,
  output logic                     proc_dvalid,
  output logic [c_nb_buf-1:0]      proc_data,
  input  logic                     proc_lock_req,
  output logic                     proc_lock_ack,
  input  logic                     cap_frame_st,
  input  logic                     cap_we,
  output logic                     fb_we,
  output logic [c_nb_img_pxls-1:0] fb_addrb,
  input  logic [c_nb_buf-1:0]      fb_doutb
);

  // One stage for the registered address plus c_rd_lat memory stages.
  localparam int STAGES = c_rd_lat;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] vga_pipe;
  logic            tag_vga, tag_proc;

  // Combinational grant so the requester can present its next address the following cycle.
  assign proc_gnt = proc_req & ~vga_rd & ~rst;
  assign tag_vga  = vld_pipe[STAGES] &  vga_pipe[STAGES];
  assign tag_proc = vld_pipe[STAGES] & ~vga_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addrb    <= '0;
      vld_pipe    <= '0;
      vga_pipe    <= '0;
      vga_pixel   <= '0;
      proc_data   <= '0;
      proc_dvalid <= 1'b0;
    end else begin
      if (vga_rd)        fb_addrb <= vga_addr;
      else if (proc_req) fb_addrb <= proc_addr;
      vld_pipe    <= {vld_pipe[STAGES-1:0], vga_rd | proc_req};
      vga_pipe    <= {vga_pipe[STAGES-1:0], vga_rd};
      proc_dvalid <= tag_proc;
      if (tag_vga)  vga_pixel <= fb_doutb;
      if (tag_proc) proc_data <= fb_doutb;
    end
  end

  fb_lock_fsm u_lock (
    .clk           (clk),
    .rst           (rst),
    .proc_lock_req (proc_lock_req),
    .cap_frame_st  (cap_frame_st),
    .cap_we        (cap_we),
    .fb_we         (fb_we),
    .proc_lock_ack (proc_lock_ack)
  );

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Scoreboard bench: driver predicts read results into queues, negedge monitor pops and compares.
module tb_frame_buf_arbiter;
  import frame_buf_arbiter_pkg::*;

  localparam int AW  = C_NB_IMG_PXLS;
  localparam int DW  = C_NB_BUF;
  localparam int LAT = C_RD_LAT;

  logic          clk, rst;
  logic          vga_rd, proc_req, proc_gnt, proc_dvalid;
  logic [AW-1:0] vga_addr, proc_addr, fb_addrb;
  logic [DW-1:0] vga_pixel, proc_data, fb_doutb;
  logic          proc_lock_req, proc_lock_ack, cap_frame_st, cap_we, fb_we;

  frame_buf_arbiter #(.c_nb_img_pxls(AW), .c_nb_buf(DW), .c_rd_lat(LAT)) dut (
    .clk(clk), .rst(rst),
    .vga_rd(vga_rd), .vga_addr(vga_addr), .vga_pixel(vga_pixel),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(proc_gnt),
    .proc_dvalid(proc_dvalid), .proc_data(proc_data),
    .proc_lock_req(proc_lock_req), .proc_lock_ack(proc_lock_ack),
    .cap_frame_st(cap_frame_st), .cap_we(cap_we), .fb_we(fb_we),
    .fb_addrb(fb_addrb), .fb_doutb(fb_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: content = address[11:0], LAT cycles from registered address to data.
  logic [DW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= fb_addrb[DW-1:0];
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign fb_doutb = mpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t vga_q[$];
  exp_t proc_q[$];
  exp_t mon_e;
  logic [DW-1:0] vga_cur = '0;
  int  checks = 0, errors = 0;
  int  gnt_cnt = 0, dv_cnt = 0;
  bit  hold_en = 1'b0, discard = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Requests enter at cycle k; registered outputs show the data in cycle k+LAT+2.
  always @(negedge clk) begin
    if (vga_q.size() > 0 && vga_q[0].due == cyc) begin
      vga_cur = vga_q[0].data;
      void'(vga_q.pop_front());
      chk("vga_pixel", 32'(vga_pixel), 32'(vga_cur));
    end else if (hold_en) begin
      chk("vga_hold", 32'(vga_pixel), 32'(vga_cur));
    end
    if (proc_dvalid === 1'b1) begin
      dv_cnt++;
      if (proc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL proc_dvalid_spurious: got dvalid with no outstanding grant (cycle %0d)", cyc);
      end else begin
        mon_e = proc_q.pop_front();
        chk("proc_data", 32'(proc_data), 32'(mon_e.data));
        chk("proc_lat", 32'(cyc), 32'(mon_e.due));
      end
    end else if (proc_q.size() > 0 && proc_q[0].due <= cyc) begin
      checks++; errors++;
      $display("FAIL proc_dvalid_missing: got none expected data %0h (cycle %0d)", proc_q[0].data, cyc);
      void'(proc_q.pop_front());
    end
  end

  // One cycle: predict from current inputs, check gnt and optional lock outputs, advance.
  task automatic step(input bit lk = 1'b0, input logic ew = 1'b0, input logic ea = 1'b0);
    logic g;
    g = proc_req && !vga_rd && !rst;
    if (!discard && !rst) begin
      if (vga_rd) vga_q.push_back('{cyc + LAT + 2, vga_addr[DW-1:0]});
      if (g)      proc_q.push_back('{cyc + LAT + 2, proc_addr[DW-1:0]});
    end
    @(negedge clk);
    chk("proc_gnt", 32'(proc_gnt), 32'(g));
    if (proc_gnt) gnt_cnt++;
    if (lk) begin
      chk("fb_we", 32'(fb_we), 32'(ew));
      chk("proc_lock_ack", 32'(proc_lock_ack), 32'(ea));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0, d0;
    rst = 1'b1; vga_rd = 1'b0; vga_addr = '0; proc_req = 1'b0; proc_addr = '0;
    proc_lock_req = 1'b0; cap_frame_st = 1'b0; cap_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vga_pixel", 32'(vga_pixel), 0);
    chk("rst_proc_data", 32'(proc_data), 0);
    chk("rst_proc_dvalid", 32'(proc_dvalid), 0);
    chk("rst_proc_gnt", 32'(proc_gnt), 0);
    chk("rst_lock_ack", 32'(proc_lock_ack), 0);
    chk("rst_fb_addrb", 32'(fb_addrb), 0);
    rst = 1'b0;
    hold_en = 1'b1;

    // 1: VGA reads every 4th cycle over the whole image
    for (int a = 0; a < 4800; a++) begin
      vga_rd = 1'b1; vga_addr = AW'(a);
      step();
      vga_rd = 1'b0;
      repeat (3) step();
    end

    // 2: same-cycle collision, VGA wins and processing is granted one cycle later
    vga_rd = 1'b1; vga_addr = AW'(5); proc_req = 1'b1; proc_addr = AW'(100);
    step();
    vga_rd = 1'b0;
    step();
    proc_req = 1'b0;
    repeat (LAT + 3) step();

    // 3: streaming processing reads interleaved with VGA every 4th cycle
    g0 = gnt_cnt; d0 = dv_cnt; n = 0;
    for (int i = 0; i < 20; i++) begin
      vga_rd = (i % 4 == 0); vga_addr = AW'(2000 + i);
      proc_req = 1'b1; proc_addr = AW'(300 + n);
      if (!vga_rd) n++;
      step();
    end
    vga_rd = 1'b0; proc_req = 1'b0;
    repeat (LAT + 4) step();
    chk("stream_gnt_count", 32'(gnt_cnt - g0), 15);
    chk("stream_dvalid_count", 32'(dv_cnt - d0), 15);

    // 4: lock waits for frame start, then blocks the whole frame
    cap_we = 1'b1;
    cap_frame_st = 1'b1; step(1, 1, 0);
    cap_frame_st = 1'b0; proc_lock_req = 1'b1; step(1, 1, 0);
    repeat (3) step(1, 1, 0);
    cap_frame_st = 1'b1; step(1, 0, 0);
    cap_frame_st = 1'b0; repeat (3) step(1, 0, 1);
    cap_we = 1'b0; step(1, 0, 1);
    cap_we = 1'b1; cap_frame_st = 1'b1; step(1, 0, 1);
    cap_frame_st = 1'b0;

    // 5: unlock waits for frame start; re-raising lock_req before it keeps the lock
    proc_lock_req = 1'b0; step(1, 0, 1);
    repeat (2) step(1, 0, 1);
    proc_lock_req = 1'b1; step(1, 0, 1);
    step(1, 0, 1);
    proc_lock_req = 1'b0; step(1, 0, 1);
    cap_frame_st = 1'b1; step(1, 0, 1);
    cap_frame_st = 1'b0; repeat (2) step(1, 1, 0);
    // lock_req drop and frame start together in LOCK_WAIT: drop wins
    proc_lock_req = 1'b1; step(1, 1, 0);
    proc_lock_req = 1'b0; cap_frame_st = 1'b1; step(1, 1, 0);
    cap_frame_st = 1'b0; repeat (2) step(1, 1, 0);

    // 6: reset with two reads in flight while locked
    proc_lock_req = 1'b1; step(1, 1, 0);
    cap_frame_st = 1'b1; step(1, 0, 0);
    cap_frame_st = 1'b0; step(1, 0, 1);
    hold_en = 1'b0; discard = 1'b1;
    proc_req = 1'b1; proc_addr = AW'(50); step();
    proc_addr = AW'(51); step();
    proc_req = 1'b0; rst = 1'b1; step();
    rst = 1'b0; proc_lock_req = 1'b0; discard = 1'b0;
    @(negedge clk);
    chk("post_rst_dvalid", 32'(proc_dvalid), 0);
    chk("post_rst_ack", 32'(proc_lock_ack), 0);
    chk("post_rst_fb_we", 32'(fb_we), 1);
    chk("post_rst_vga_pixel", 32'(vga_pixel), 0);
    chk("post_rst_proc_data", 32'(proc_data), 0);
    chk("post_rst_fb_addrb", 32'(fb_addrb), 0);
    @(posedge clk); #1;
    repeat (LAT + 2) step(1, 1, 0);
    proc_req = 1'b1; proc_addr = AW'(77); step();
    proc_req = 1'b0;
    repeat (LAT + 4) step();

    chk("vga_q_drained", 32'(vga_q.size()), 0);
    chk("proc_q_drained", 32'(proc_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
